hazard_scoreboard: RTL and testbench

Parametrised hazard controller for the in-order RV32 pipeline, replacing the fixed five-stage forward/stall logic with a per-register scoreboard that tracks outstanding long-latency writes (loads, mul/div). It generates per-stage stall, bubble and flush vectors, nearest-stage forwarding selects, and a debug halt/single-step state machine. It sits between the decode stage, the execution units' completion ports and the debug module.

---
 rtl/hazard_pkg.sv | 18 +
 rtl/hazard_sb_bits.sv | 52 +++++
 rtl/hazard_scoreboard.sv | 157 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and default geometry for the pipeline hazard controller.
package hazard_pkg;

    localparam int DEF_NUM_REGS   = 32;
    localparam int DEF_NUM_STAGES = 5;
    localparam int DEF_ID_STAGE   = 1;
    localparam int DEF_FW_STAGES  = 2;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        STEP = 2'd2
    } dbg_state_e;

    typedef logic [$clog2(DEF_NUM_REGS)-1:0]    reg_idx_t;
    typedef logic [$clog2(DEF_FW_STAGES+1)-1:0] fw_sel_t;

endpackage

// File: rtl/hazard_sb_bits.sv
// Pending-write bit array: one set port, NUM_CMPL clear ports, three read ports.
// Register 0 is hard-wired clear so x0 never produces a hazard.
module hazard_sb_bits
    import hazard_pkg::*;
#(
    parameter  int NUM_REGS = DEF_NUM_REGS,
    parameter  int NUM_CMPL = 2,
    localparam int RW       = $clog2(NUM_REGS)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_set_en,
    input  logic [RW-1:0]          i_set_idx,
    input  logic [NUM_CMPL-1:0]    i_clr_valid,
    input  logic [NUM_CMPL*RW-1:0] i_clr_idx,
    input  logic [RW-1:0]          i_rd_a,
    input  logic [RW-1:0]          i_rd_b,
    input  logic [RW-1:0]          i_rd_c,
    output logic                   o_hit_a,
    output logic                   o_hit_b,
    output logic                   o_hit_c,
    output logic [NUM_REGS-1:0]    o_bits
);

    logic [NUM_REGS-1:0] r_bits;
    logic [NUM_REGS-1:0] w_next;

    // Next pending vector: clears first, then the (never colliding) set.
    always_comb begin
        w_next = r_bits;
        for (int j = 0; j < NUM_CMPL; j++) begin
            w_next[i_clr_idx[j*RW +: RW]] = w_next[i_clr_idx[j*RW +: RW]] & ~i_clr_valid[j];
        end
        w_next[i_set_idx] = w_next[i_set_idx] | i_set_en;
        w_next[0]         = 1'b0;
    end

    // Pending bit storage.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bits <= '0;
        end else begin
            r_bits <= w_next;
        end
    end

    assign o_hit_a = r_bits[i_rd_a];
    assign o_hit_b = r_bits[i_rd_b];
    assign o_hit_c = r_bits[i_rd_c];
    assign o_bits  = r_bits;

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard-based hazard controller: stall/bubble/flush vectors, forwarding
// selects, debug halt/step FSM and a hazard-stall watchdog.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter  int NUM_REGS   = DEF_NUM_REGS,
    parameter  int NUM_STAGES = DEF_NUM_STAGES,
    parameter  int ID_STAGE   = DEF_ID_STAGE,
    parameter  int FW_STAGES  = DEF_FW_STAGES,
    parameter  int NUM_CMPL   = 2,
    parameter  int TIMEOUT    = 255,
    localparam int RW         = $clog2(NUM_REGS),
    localparam int SW         = $clog2(FW_STAGES+1)
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic                    iIssue_valid,
    input  logic [RW-1:0]           iIssue_rs1,
    input  logic [RW-1:0]           iIssue_rs2,
    input  logic [RW-1:0]           iIssue_rd,
    input  logic                    iIssue_long,
    input  logic [NUM_CMPL-1:0]     iCmpl_valid,
    input  logic [NUM_CMPL*RW-1:0]  iCmpl_rd,
    input  logic [FW_STAGES-1:0]    iFwd_wen,
    input  logic [FW_STAGES*RW-1:0] iFwd_rd,
    input  logic                    iBrTrue,
    input  logic                    iStall_mem,
    input  logic                    iDbg_halt,
    input  logic                    iDbg_step,
    output logic [NUM_STAGES-1:0]   oStall,
    output logic                    oBubble,
    output logic [NUM_STAGES-1:0]   oFlush,
    output logic [SW-1:0]           oFwS1_sel,
    output logic [SW-1:0]           oFwS2_sel,
    output logic                    oDbg_halted,
    output logic                    oErr_timeout,
    output logic [NUM_REGS-1:0]     oSb_pending
);

    localparam logic [NUM_STAGES-1:0] ID_MASK = NUM_STAGES'((64'd1 << (ID_STAGE + 1)) - 64'd1);
    localparam int                    CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]         TO_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0]         TO_M1   = CW'(TIMEOUT - 1);

    dbg_state_e     r_state;
    logic [CW-1:0]  r_wd_cnt;
    logic           r_err;
    logic           w_hit_rs1, w_hit_rs2, w_hit_rd;
    logic           w_hz, w_full, w_accept, w_set;

    hazard_sb_bits #(.NUM_REGS(NUM_REGS), .NUM_CMPL(NUM_CMPL)) u_sb (
        .i_clk      (iClk),
        .i_rst      (iRst),
        .i_set_en   (w_set),
        .i_set_idx  (iIssue_rd),
        .i_clr_valid(iCmpl_valid),
        .i_clr_idx  (iCmpl_rd),
        .i_rd_a     (iIssue_rs1),
        .i_rd_b     (iIssue_rs2),
        .i_rd_c     (iIssue_rd),
        .o_hit_a    (w_hit_rs1),
        .o_hit_b    (w_hit_rs2),
        .o_hit_c    (w_hit_rd),
        .o_bits     (oSb_pending)
    );

    // Nearest producing stage wins; x0 never forwards.
    function automatic logic [SW-1:0] fw_select(input logic [RW-1:0] rs,
                                                input logic [FW_STAGES-1:0] wen,
                                                input logic [FW_STAGES*RW-1:0] rd);
        logic [SW-1:0] sel;
        sel = '0;
        for (int k = FW_STAGES; k >= 1; k--) begin
            if (wen[k-1] && (rd[(k-1)*RW +: RW] == rs) && (rs != '0)) begin
                sel = SW'(k);
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    assign w_hz     = iIssue_valid & (w_hit_rs1 | w_hit_rs2 | w_hit_rd);
    assign w_full   = iStall_mem | (r_state == HALT);
    assign w_accept = iIssue_valid & ~w_hz & ~w_full & ~iBrTrue;
    assign w_set    = w_accept & iIssue_long & (iIssue_rd != '0);

    // Stall/bubble/flush decode; full-pipe hold outranks the scoreboard stall.
    always_comb begin
        oStall  = '0;
        oFlush  = '0;
        oBubble = 1'b0;
        if (iRst) begin
            oFlush = '1;
        end else begin
            if (w_full) begin
                oStall = '1;
            end else if (w_hz) begin
                oStall  = ID_MASK;
                oBubble = 1'b1;
            end else begin
                oStall = '0;
            end
            if (iBrTrue) begin
                oFlush = ID_MASK;
                oStall = oStall & ~ID_MASK;
            end else begin
                oFlush = '0;
            end
        end
    end

    assign oFwS1_sel    = fw_select(iIssue_rs1, iFwd_wen, iFwd_rd);
    assign oFwS2_sel    = fw_select(iIssue_rs2, iFwd_wen, iFwd_rd);
    assign oDbg_halted  = (r_state == HALT);
    assign oErr_timeout = r_err;

    // Debug halt / single-step state machine.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state <= RUN;
        end else begin
            case (r_state)
                RUN:     r_state <= iDbg_halt ? HALT : RUN;
                HALT: begin
                    if (iDbg_step) begin
                        r_state <= STEP;
                    end else if (!iDbg_halt) begin
                        r_state <= RUN;
                    end else begin
                        r_state <= HALT;
                    end
                end
                STEP:    r_state <= w_accept ? HALT : STEP;
                default: r_state <= RUN;
            endcase
        end
    end

    // Watchdog: counts consecutive hazard cycles, saturates, error is sticky.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else if (w_hz) begin
            if (r_wd_cnt != TO_MAX) begin
                r_wd_cnt <= r_wd_cnt + CW'(1);
            end
            if (r_wd_cnt >= TO_M1) begin
                r_err <= 1'b1;
            end
        end else begin
            r_wd_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed bench for hazard_scoreboard against a behavioural model.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    logic        iClk, iRst, iIssue_valid, iIssue_long, iBrTrue, iStall_mem, iDbg_halt, iDbg_step;
    reg_idx_t    iIssue_rs1, iIssue_rs2, iIssue_rd;
    logic [1:0]  iCmpl_valid, iFwd_wen;
    logic [9:0]  iCmpl_rd, iFwd_rd;
    logic [4:0]  oStall, oFlush;
    logic        oBubble, oDbg_halted, oErr_timeout;
    fw_sel_t     oFwS1_sel, oFwS2_sel;
    logic [31:0] oSb_pending;

    int n_total = 0;
    int n_bad   = 0;

    bit m_pend[32];
    int m_state;
    int m_cnt;
    bit m_err;

    hazard_scoreboard dut (
        .iClk(iClk), .iRst(iRst), .iIssue_valid(iIssue_valid), .iIssue_rs1(iIssue_rs1),
        .iIssue_rs2(iIssue_rs2), .iIssue_rd(iIssue_rd), .iIssue_long(iIssue_long),
        .iCmpl_valid(iCmpl_valid), .iCmpl_rd(iCmpl_rd), .iFwd_wen(iFwd_wen), .iFwd_rd(iFwd_rd),
        .iBrTrue(iBrTrue), .iStall_mem(iStall_mem), .iDbg_halt(iDbg_halt), .iDbg_step(iDbg_step),
        .oStall(oStall), .oBubble(oBubble), .oFlush(oFlush), .oFwS1_sel(oFwS1_sel),
        .oFwS2_sel(oFwS2_sel), .oDbg_halted(oDbg_halted), .oErr_timeout(oErr_timeout),
        .oSb_pending(oSb_pending)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_state = 0;
        m_cnt   = 0;
        m_err   = 1'b0;
    endtask

    function automatic int exp_sel(input logic [4:0] rs);
        if (rs == 5'd0) return 0;
        for (int k = 1; k <= 2; k++) begin
            if (iFwd_wen[k-1] && iFwd_rd[(k-1)*5 +: 5] == rs) return k;
        end
        return 0;
    endfunction

    function automatic bit hazard_now();
        return iIssue_valid && ((iIssue_rs1 != 5'd0 && m_pend[iIssue_rs1]) ||
                                (iIssue_rs2 != 5'd0 && m_pend[iIssue_rs2]) ||
                                (iIssue_rd  != 5'd0 && m_pend[iIssue_rd]));
    endfunction

    task automatic set_idle();
        iIssue_valid = 1'b0; iIssue_rs1 = 5'd0; iIssue_rs2 = 5'd0; iIssue_rd = 5'd0;
        iIssue_long = 1'b0; iCmpl_valid = 2'b00; iCmpl_rd = 10'd0; iFwd_wen = 2'b00;
        iFwd_rd = 10'd0; iBrTrue = 1'b0; iStall_mem = 1'b0; iDbg_step = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input logic lng);
        iIssue_valid = 1'b1; iIssue_rs1 = rs1; iIssue_rs2 = rs2; iIssue_rd = rd; iIssue_long = lng;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
    task automatic step_cycle();
        bit         hz, full, acc;
        logic [4:0] es, ef;
        logic       eb;
        logic [31:0] pv;
        #4;
        if (iRst) model_reset();
        hz   = hazard_now();
        full = iStall_mem || (m_state == 1);
        if (iRst) begin
            es = 5'b00000; ef = 5'b11111; eb = 1'b0;
        end else begin
            es = full ? 5'b11111 : (hz ? 5'b00011 : 5'b00000);
            eb = !full && hz;
            ef = iBrTrue ? 5'b00011 : 5'b00000;
            if (iBrTrue) es[1:0] = 2'b00;
        end
        for (int i = 0; i < 32; i++) pv[i] = m_pend[i];
        check_eq("stall",   64'(oStall),       64'(es));
        check_eq("bubble",  64'(oBubble),      64'(eb));
        check_eq("flush",   64'(oFlush),       64'(ef));
        check_eq("fw1",     64'(oFwS1_sel),    64'(exp_sel(iIssue_rs1)));
        check_eq("fw2",     64'(oFwS2_sel),    64'(exp_sel(iIssue_rs2)));
        check_eq("halted",  64'(oDbg_halted),  64'(m_state == 1));
        check_eq("timeout", 64'(oErr_timeout), 64'(m_err));
        check_eq("pending", 64'(oSb_pending),  64'(pv));
        @(posedge iClk);
        if (!iRst) begin
            acc = iIssue_valid && !hz && !full && !iBrTrue;
            for (int j = 0; j < 2; j++) if (iCmpl_valid[j]) m_pend[iCmpl_rd[j*5 +: 5]] = 1'b0;
            if (acc && iIssue_long && iIssue_rd != 5'd0) m_pend[iIssue_rd] = 1'b1;
            case (m_state)
                0:       if (iDbg_halt) m_state = 1;
                1:       if (iDbg_step) m_state = 2; else if (!iDbg_halt) m_state = 0;
                default: if (acc) m_state = 1;
            endcase
            if (hz) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt >= 255) m_err = 1'b1;
            end else begin
                m_cnt = 0;
            end
        end
        #1;
    endtask

    initial begin
        int r;
        model_reset();
        set_idle();
        iDbg_halt = 1'b0;
        iRst = 1'b1;
        step_cycle(); step_cycle();
        iRst = 1'b0;
        step_cycle();

        // load-use stall released the cycle after completion
        issue(5'd0, 5'd0, 5'd5, 1'b1); step_cycle();
        issue(5'd5, 5'd0, 5'd9, 1'b0); step_cycle(); step_cycle();
        iCmpl_valid = 2'b01; iCmpl_rd = 10'd5; step_cycle();
        iCmpl_valid = 2'b00; step_cycle();
        set_idle(); step_cycle();

        // x0 is never tracked; WAW stalls
        issue(5'd0, 5'd0, 5'd0, 1'b1); step_cycle();
        set_idle(); step_cycle();
        issue(5'd0, 5'd0, 5'd7, 1'b1); step_cycle();
        issue(5'd1, 5'd2, 5'd7, 1'b0); step_cycle(); step_cycle();
        iCmpl_valid = 2'b10; iCmpl_rd = {5'd7, 5'd0}; step_cycle();
        iCmpl_valid = 2'b00; step_cycle();
        set_idle(); step_cycle();

        // forwarding priority
        iFwd_rd = {5'd3, 5'd3};
        iFwd_wen = 2'b11; issue(5'd0, 5'd3, 5'd0, 1'b0); step_cycle();
        iFwd_wen = 2'b10; step_cycle();
        iIssue_rs2 = 5'd0; step_cycle();
        set_idle(); step_cycle();

        // branch during hazard with memory stall
        issue(5'd0, 5'd0, 5'd4, 1'b1); step_cycle();
        issue(5'd4, 5'd0, 5'd8, 1'b1); iBrTrue = 1'b1; iStall_mem = 1'b1; step_cycle();
        set_idle(); iCmpl_valid = 2'b01; iCmpl_rd = 10'd4; step_cycle();
        set_idle(); step_cycle();

        // debug halt, single step, release
        iDbg_halt = 1'b1; step_cycle(); step_cycle();
        issue(5'd0, 5'd0, 5'd10, 1'b1); iDbg_step = 1'b1; step_cycle();
        iDbg_step = 1'b0; step_cycle();
        issue(5'd0, 5'd0, 5'd11, 1'b1); step_cycle(); step_cycle();
        iDbg_halt = 1'b0; step_cycle();
        set_idle(); iCmpl_valid = 2'b11; iCmpl_rd = {5'd10, 5'd10}; step_cycle();
        set_idle(); step_cycle();

        // watchdog saturation and stickiness
        issue(5'd0, 5'd0, 5'd12, 1'b1); step_cycle();
        issue(5'd12, 5'd0, 5'd13, 1'b0);
        for (int i = 0; i < 258; i++) step_cycle();
        set_idle(); iCmpl_valid = 2'b01; iCmpl_rd = 10'd12; step_cycle();
        set_idle(); step_cycle(); step_cycle();

        // async reset mid-STEP with pending bits set
        issue(5'd0, 5'd0, 5'd13, 1'b1); step_cycle();
        set_idle(); iDbg_halt = 1'b1; step_cycle();
        iDbg_step = 1'b1; step_cycle();
        iDbg_step = 1'b0; step_cycle();
        iRst = 1'b1; step_cycle();
        iRst = 1'b0; iDbg_halt = 1'b0; step_cycle();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            set_idle();
            iIssue_valid = ($urandom % 4) != 0;
            iIssue_rs1   = 5'($urandom_range(0, 7));
            iIssue_rs2   = 5'($urandom_range(0, 7));
            iIssue_rd    = 5'($urandom_range(0, 7));
            iIssue_long  = ($urandom % 5) < 2;
            for (int j = 0; j < 2; j++) begin
                r = $urandom_range(0, 7);
                iCmpl_rd[j*5 +: 5] = 5'(r);
                iCmpl_valid[j] = (($urandom % 2) == 0) && m_pend[r];
            end
            iFwd_wen   = 2'($urandom);
            iFwd_rd    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            iBrTrue    = ($urandom % 10) == 0;
            iStall_mem = ($urandom % 10) == 0;
            iDbg_step  = ($urandom % 5) == 0;
            if (($urandom % 40) == 0) iDbg_halt = ~iDbg_halt;
            iRst       = ($urandom % 500) == 0;
            step_cycle();
        end
        iRst = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
